pcm_frame_fifo: RTL and testbench

//  Elastic buffer for 256-bit PCM frames (8 ch x 32b) between gainBal output
//  (dout_val/dout) and p2tdm input (valid/pdata/ack). Absorbs jitter between
//  DSP frame production and serializer consumption. Drops new frames on

---
 rtl/pcm_frame_fifo.sv | 97 +++++++++
 tb/tb_pcm_frame_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_fifo.sv
// Elastic frame buffer between the gain/balance stage and the TDM serializer.
// First-word fall-through FIFO that drops new frames when full and counts the drops.
module pcm_frame_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              din_val,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] pdata,
  input  logic              ack,
  output logic [AW:0]       level,
  output logic              full,
  input  logic              dropClr,
  output logic [15:0]       dropped,
  output logic              droppedIncr
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_level;
  logic              r_valid;
  logic              r_full;
  logic [15:0]       r_dropped;
  logic              r_droppedIncr;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [AW:0]       w_levelNext;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the new frame.
  assign w_pop       = enable & r_valid & ack;
  assign w_push      = enable & din_val & (~r_full | w_pop);
  assign w_drop      = enable & din_val & r_full & ~w_pop;
  assign w_levelNext = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else if (!enable) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_level <= w_levelNext;
      r_valid <= (w_levelNext != '0);
      r_full  <= (w_levelNext == (AW+1)'(DEPTH));
    end
  end

  // Clear wins over a same-cycle drop, but the drop pulse is still reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped     <= '0;
      r_droppedIncr <= 1'b0;
    end else begin
      r_droppedIncr <= w_drop;
      if (dropClr) begin
        r_dropped <= '0;
      end else if (w_drop && r_dropped != 16'hFFFF) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  assign valid       = r_valid;
  assign pdata       = r_valid ? r_mem[r_rdPtr] : '0;
  assign level       = r_level;
  assign full        = r_full;
  assign dropped     = r_dropped;
  assign droppedIncr = r_droppedIncr;

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// Scoreboard bench for pcm_frame_fifo: directed pushes queue expected frames,
// a negedge monitor pops and compares whenever the consumer takes the head.
module tb_pcm_frame_fifo;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              din_val;
  logic [DATA_W-1:0] din;
  logic              valid;
  logic [DATA_W-1:0] pdata;
  logic              ack;
  logic [AW:0]       level;
  logic              full;
  logic              dropClr;
  logic [15:0]       dropped;
  logic              droppedIncr;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] expQ [$];

  pcm_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din_val(din_val), .din(din),
    .valid(valid), .pdata(pdata), .ack(ack), .level(level), .full(full),
    .dropClr(dropClr), .dropped(dropped), .droppedIncr(droppedIncr)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mkFrame(input int n);
    logic [DATA_W-1:0] f;
    f = '0;
    for (int ch = 0; ch < 8; ch++) begin
      f[ch*32 +: 32] = {n[15:0], ch[7:0], 8'hC3};
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus; a frame expected to be stored goes to the scoreboard.
  task automatic applyStimulus(input logic dv, input int frameId, input logic a,
                               input logic expectStore);
    din_val = dv;
    din     = mkFrame(frameId);
    ack     = a;
    if (expectStore) expQ.push_back(mkFrame(frameId));
    step();
    din_val = 1'b0;
    ack     = 1'b0;
  endtask

  // Consumer-side monitor: every accepted pop must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && enable && valid && ack) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL pop_unexpected: got %0h expected no frame", pdata);
      end else begin
        checkOutput("pop_data", pdata, expQ.pop_front());
      end
    end
    if (!rst && !valid && pdata !== '0) begin
      checkOutput("pdata_masked", pdata, '0);
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; din_val = 1'b0; din = '0; ack = 1'b0; dropClr = 1'b0;
    step(); step();
    checkOutput("rst_level", DATA_W'(level), 0);
    checkOutput("rst_valid", DATA_W'(valid), 0);
    checkOutput("rst_full", DATA_W'(full), 0);
    checkOutput("rst_dropped", DATA_W'(dropped), 0);
    checkOutput("rst_droppedIncr", DATA_W'(droppedIncr), 0);
    checkOutput("rst_pdata", pdata, 0);
    rst = 1'b0;
    enable = 1'b1;
    step();

    // Three frames with gaps, then drain
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, i, 1'b0, 1'b1);
      if (i == 1) begin
        checkOutput("fwft_valid", DATA_W'(valid), 1);
        checkOutput("fwft_pdata", pdata, mkFrame(1));
      end
      step(); step();
    end
    checkOutput("t1_level", DATA_W'(level), 3);
    checkOutput("t1_pdata", pdata, mkFrame(1));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t1_valid_end", DATA_W'(valid), 0);
    checkOutput("t1_level_end", DATA_W'(level), 0);

    // Fill, then overflow drop
    for (int i = 11; i <= 14; i++) applyStimulus(1'b1, i, 1'b0, 1'b1);
    checkOutput("t2_full", DATA_W'(full), 1);
    checkOutput("t2_level", DATA_W'(level), 4);
    applyStimulus(1'b1, 15, 1'b0, 1'b0);
    checkOutput("t2_droppedIncr", DATA_W'(droppedIncr), 1);
    checkOutput("t2_dropped", DATA_W'(dropped), 1);
    step();
    checkOutput("t2_droppedIncr_pulse", DATA_W'(droppedIncr), 0);
    checkOutput("t2_head", pdata, mkFrame(11));
    checkOutput("t2_level_after", DATA_W'(level), 4);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 20; i < 30; i++) begin
      applyStimulus(1'b1, i, 1'b1, 1'b1);
      checkOutput("t3_level", DATA_W'(level), 4);
      checkOutput("t3_noDrop", DATA_W'(droppedIncr), 0);
    end
    checkOutput("t3_dropped", DATA_W'(dropped), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t3_level_end", DATA_W'(level), 0);

    // Drop counter saturation, clear, and clear-vs-drop priority
    for (int i = 30; i <= 33; i++) applyStimulus(1'b1, i, 1'b0, 1'b1);
    dropClr = 1'b1; step(); dropClr = 1'b0;
    checkOutput("t4_clr", DATA_W'(dropped), 0);
    for (int i = 0; i < 65534; i++) applyStimulus(1'b1, 99, 1'b0, 1'b0);
    checkOutput("t4_cnt_FFFE", DATA_W'(dropped), 16'hFFFE);
    applyStimulus(1'b1, 99, 1'b0, 1'b0);
    checkOutput("t4_cnt_FFFF", DATA_W'(dropped), 16'hFFFF);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 99, 1'b0, 1'b0);
    checkOutput("t4_saturated", DATA_W'(dropped), 16'hFFFF);
    checkOutput("t4_head", pdata, mkFrame(30));
    dropClr = 1'b1;
    applyStimulus(1'b1, 99, 1'b0, 1'b0);
    dropClr = 1'b0;
    checkOutput("t4_clr_priority", DATA_W'(dropped), 0);
    checkOutput("t4_clr_pulse", DATA_W'(droppedIncr), 1);
    applyStimulus(1'b1, 99, 1'b0, 1'b0);
    checkOutput("t4_after_clr", DATA_W'(dropped), 1);

    // Flush with enable low, then restart
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t5_level3", DATA_W'(level), 3);
    enable = 1'b0;
    applyStimulus(1'b1, 98, 1'b1, 1'b0);
    expQ.delete();
    checkOutput("t5_flush_level", DATA_W'(level), 0);
    checkOutput("t5_flush_valid", DATA_W'(valid), 0);
    checkOutput("t5_flush_full", DATA_W'(full), 0);
    checkOutput("t5_dropped_kept", DATA_W'(dropped), 1);
    checkOutput("t5_noDrop", DATA_W'(droppedIncr), 0);
    enable = 1'b1;
    applyStimulus(1'b1, 40, 1'b0, 1'b1);
    checkOutput("t5_valid", DATA_W'(valid), 1);
    checkOutput("t5_pdata", pdata, mkFrame(40));
    checkOutput("t5_level1", DATA_W'(level), 1);

    // Reset mid-operation with a same-cycle strobe
    applyStimulus(1'b1, 41, 1'b0, 1'b1);
    checkOutput("t6_level2", DATA_W'(level), 2);
    rst = 1'b1;
    applyStimulus(1'b1, 42, 1'b0, 1'b0);
    rst = 1'b0;
    expQ.delete();
    checkOutput("t6_level", DATA_W'(level), 0);
    checkOutput("t6_valid", DATA_W'(valid), 0);
    checkOutput("t6_dropped", DATA_W'(dropped), 0);
    step();
    checkOutput("t6_not_stored", DATA_W'(level), 0);
    checkOutput("t6_pdata", pdata, 0);

    checkOutput("scoreboard_empty", DATA_W'(expQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
